// File: rtl/scan_sequencer.sv
// scan_sequencer: film-scan sequencer driving the stepper motor and per-line CCD capture triggers.
//   clk_100M   system clock
//   rst_n      asynchronous active-low reset
//   run        bit0 scan enable (rising edge starts, low aborts), bit1 direction
//   lines      number of lines per scan (0 = no scan)
//   reso_div   motor steps per line minus 1
//   ccd_busy   CCD readout in progress; paces each line
//   motor_en / motor_dir / motor_step   stepper driver controls
//   line_trig  line capture trigger pulse
//   scan_busy  high whenever not idle
//   scan_done  one-cycle pulse on normal completion
//   line_count lines completed in current/last scan
`timescale 1ns/1ps
module scan_sequencer #(
  parameter int STEP_PERIOD   = 1000,
  parameter int STEP_PULSE_W  = 200,
  parameter int LINE_TRIG_W   = 10,
  parameter int SETTLE_CYCLES = 100000
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic [7:0]  run,
  input  logic [23:0] lines,
  input  logic [7:0]  reso_div,
  input  logic        ccd_busy,
  output logic        motor_en,
  output logic        motor_dir,
  output logic        motor_step,
  output logic        line_trig,
  output logic        scan_busy,
  output logic        scan_done,
  output logic [23:0] line_count
);
  localparam int MX = STEP_PERIOD > SETTLE_CYCLES ? STEP_PERIOD : SETTLE_CYCLES;
  localparam int CW = $clog2(MX) + 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TRIG_LD   = CW'(LINE_TRIG_W - 1);
  localparam logic [CW-1:0] HI_LD     = CW'(STEP_PULSE_W - 1);
  localparam logic [CW-1:0] LO_LD     = CW'(STEP_PERIOD - STEP_PULSE_W - 1);
  typedef enum logic [2:0] {IDLE, SETTLE, TRIG, WAIT_CCD, STEP_HI, STEP_LO, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [8:0] steps;
  logic [23:0] lines_q;
  logic [7:0] div_q;
  logic run0_q, abort_q;
  logic cnt_zero, last_step, last_line, finish, stop;
  logic unused_run;
  assign unused_run = ^run[7:2];
  assign cnt_zero  = cnt == '0;
  assign last_step = steps == {1'b0, div_q};
  assign last_line = (line_count + 24'd1) == lines_q;
  assign finish    = state == STEP_LO && cnt_zero && last_step && last_line;
  // A step pulse in flight always completes its full width before an abort takes effect;
  // abort_q remembers a run[0] drop seen earlier in the pulse.
  assign stop = state == STEP_HI ? cnt_zero && (abort_q || !run[0])
              : !run[0] && !finish && state != IDLE && state != DONE;
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      steps      <= '0;
      lines_q    <= '0;
      div_q      <= '0;
      run0_q     <= 1'b0;
      abort_q    <= 1'b0;
      motor_en   <= 1'b0;
      motor_dir  <= 1'b0;
      motor_step <= 1'b0;
      line_trig  <= 1'b0;
      scan_busy  <= 1'b0;
      scan_done  <= 1'b0;
      line_count <= '0;
    end else begin
      run0_q    <= run[0];
      abort_q   <= state == STEP_HI && (abort_q || !run[0]);
      cnt       <= cnt - 1'b1;
      scan_done <= 1'b0;
      case (state)
        IDLE: if (run[0] && !run0_q && lines != '0) begin
          state      <= SETTLE;
          lines_q    <= lines;
          div_q      <= reso_div;
          motor_dir  <= run[1];
          motor_en   <= 1'b1;
          scan_busy  <= 1'b1;
          line_count <= '0;
          cnt        <= SETTLE_LD;
        end
        SETTLE: if (cnt_zero) begin
          state     <= TRIG;
          line_trig <= 1'b1;
          cnt       <= TRIG_LD;
        end
        TRIG: if (cnt_zero) begin
          state     <= WAIT_CCD;
          line_trig <= 1'b0;
        end
        WAIT_CCD: if (!ccd_busy) begin
          state      <= STEP_HI;
          motor_step <= 1'b1;
          steps      <= '0;
          cnt        <= HI_LD;
        end
        STEP_HI: if (cnt_zero) begin
          state      <= STEP_LO;
          motor_step <= 1'b0;
          cnt        <= LO_LD;
        end
        STEP_LO: if (cnt_zero) begin
          steps <= steps + 1'b1;
          if (!last_step) begin
            state      <= STEP_HI;
            motor_step <= 1'b1;
            cnt        <= HI_LD;
          end else begin
            line_count <= line_count + 24'd1;
            if (last_line) begin
              state     <= DONE;
              scan_done <= 1'b1;
            end else begin
              state     <= TRIG;
              line_trig <= 1'b1;
              cnt       <= TRIG_LD;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          motor_en  <= 1'b0;
          scan_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (stop) begin
        state      <= IDLE;
        motor_en   <= 1'b0;
        motor_step <= 1'b0;
        line_trig  <= 1'b0;
        scan_busy  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: self-checking bench for scan_sequencer (table vectors, trace model, corner sequences).
`timescale 1ns/1ps
module tb_scan_sequencer;
  localparam int SP = 8, PW = 2, LTW = 2, SC = 4;
  logic clk_100M = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] run = '0;
  logic [23:0] lines = '0;
  logic [7:0] reso_div = '0;
  logic ccd_busy = 1'b0;
  logic motor_en, motor_dir, motor_step, line_trig, scan_busy, scan_done;
  logic [23:0] line_count;
  int tests = 0, fails = 0;
  int busy_len = 0, busy_left = 0;
  logic trig_d = 1'b0;
  scan_sequencer #(.STEP_PERIOD(SP), .STEP_PULSE_W(PW), .LINE_TRIG_W(LTW), .SETTLE_CYCLES(SC)) dut (
    .clk_100M(clk_100M), .rst_n(rst_n), .run(run), .lines(lines), .reso_div(reso_div),
    .ccd_busy(ccd_busy), .motor_en(motor_en), .motor_dir(motor_dir), .motor_step(motor_step),
    .line_trig(line_trig), .scan_busy(scan_busy), .scan_done(scan_done), .line_count(line_count)
  );
  always #5 clk_100M = ~clk_100M;
  // CCD emulation: busy rises with the trigger and stays high for busy_len cycles.
  always @(negedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      ccd_busy = 1'b0;
      busy_left = 0;
      trig_d = 1'b0;
    end else begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) ccd_busy = 1'b0;
      end
      if (line_trig && !trig_d && busy_len > 0) begin
        ccd_busy = 1'b1;
        busy_left = busy_len;
      end
      trig_d = line_trig;
    end
  end
  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // Leaves run low for a cycle, then raises it; returns at the negedge that applied the edge.
  task automatic start(input int l, input int d, input logic [7:0] r);
    run = '0;
    @(negedge clk_100M);
    lines = 24'(l);
    reso_div = 8'(d);
    run = r;
  endtask
  typedef struct {
    int l; int d; logic [7:0] r; int b;
    int steps; int trigs; int done; int busyc; int lc;
  } vec_t;
  vec_t tbl[4];
  task automatic run_vec(input int i, input vec_t v);
    int ns = 0, nt = 0, nd = 0, nb = 0, fb = -1, ft = -1, w = 0, wmin = 999, wmax = 0, dirbad = 0;
    logic ps = 1'b0, pt = 1'b0;
    busy_len = v.b;
    start(v.l, v.d, v.r);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_100M);
      if (motor_step && !ps) ns++;
      if (line_trig && !pt) nt++;
      if (scan_done) nd++;
      if (scan_busy) begin
        nb++;
        if (fb < 0) fb = c;
      end
      if (line_trig && ft < 0) ft = c;
      if (motor_step) w++;
      else if (ps) begin
        if (w < wmin) wmin = w;
        if (w > wmax) wmax = w;
        w = 0;
      end
      if (motor_en && motor_dir != v.r[1]) dirbad++;
      ps = motor_step;
      pt = line_trig;
    end
    chk($sformatf("vec%0d steps", i), ns, v.steps);
    chk($sformatf("vec%0d trigs", i), nt, v.trigs);
    chk($sformatf("vec%0d done", i), nd, v.done);
    chk($sformatf("vec%0d busy_cycles", i), nb, v.busyc);
    chk($sformatf("vec%0d line_count", i), line_count, v.lc);
    chk($sformatf("vec%0d en_after", i), motor_en, 0);
    chk($sformatf("vec%0d dir", i), dirbad, 0);
    if (v.steps > 0) begin
      chk($sformatf("vec%0d step_wmin", i), wmin, PW);
      chk($sformatf("vec%0d step_wmax", i), wmax, PW);
      chk($sformatf("vec%0d first_trig_delay", i), ft - fb, SC);
    end
    run = '0;
  endtask
  typedef struct packed {
    logic en; logic step; logic trig; logic busy; logic done; logic [23:0] lc;
  } ev_t;
  // Expected per-cycle trace built from the scan phases: settle, then per line trigger,
  // CCD wait, and reso_div+1 step periods, then the done cycle and idle.
  task automatic run_model(input int nl, input int nd, input int b, input logic dir, input logic [5:0] junk);
    ev_t q[$];
    ev_t v;
    int wt;
    wt = b - LTW + 1 > 1 ? b - LTW + 1 : 1;
    v = '0;
    v.en = 1'b1;
    v.busy = 1'b1;
    repeat (SC) q.push_back(v);
    for (int i = 0; i < nl; i++) begin
      v.lc = 24'(i);
      v.trig = 1'b1;
      repeat (LTW) q.push_back(v);
      v.trig = 1'b0;
      repeat (wt) q.push_back(v);
      for (int s = 0; s <= nd; s++) begin
        v.step = 1'b1;
        repeat (PW) q.push_back(v);
        v.step = 1'b0;
        repeat (SP - PW) q.push_back(v);
      end
    end
    v.lc = 24'(nl);
    v.done = 1'b1;
    q.push_back(v);
    v = '0;
    v.lc = 24'(nl);
    repeat (4) q.push_back(v);
    busy_len = b;
    start(nl, nd, {junk, dir, 1'b1});
    foreach (q[k]) begin
      @(negedge clk_100M);
      if (k == 0) begin
        lines = 24'($urandom);
        reso_div = 8'($urandom);
        run[1] = ~run[1];
      end
      chk($sformatf("trace L%0d D%0d B%0d cyc%0d", nl, nd, b, k),
          {motor_en, motor_step, line_trig, scan_busy, scan_done, line_count}, q[k]);
      if (q[k].en) chk($sformatf("trace dir cyc%0d", k), motor_dir, dir);
    end
    run = '0;
  endtask
  task automatic wait_line2_step(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk_100M);
      if (motor_step && line_count == 24'd1) ok = 1'b1;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit ok;
    int cnt, dn;
    int bl[6];
    tbl[0] = '{l:0, d:0, r:8'h01, b:0,  steps:0, trigs:0, done:0, busyc:0,  lc:0};
    tbl[1] = '{l:3, d:0, r:8'h01, b:0,  steps:3, trigs:3, done:1, busyc:38, lc:3};
    tbl[2] = '{l:2, d:3, r:8'h03, b:0,  steps:8, trigs:2, done:1, busyc:75, lc:2};
    tbl[3] = '{l:2, d:0, r:8'h01, b:20, steps:2, trigs:2, done:1, busyc:63, lc:2};
    bl = '{0, 1, 2, 3, 7, 15};
    repeat (3) @(negedge clk_100M);
    chk("reset outputs", {motor_en, motor_dir, motor_step, line_trig, scan_busy, scan_done, line_count}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) run_vec(i, tbl[i]);
    run_model(2, 0, 20, 1'b0, 6'h00);
    for (int k = 0; k < 6; k++)
      run_model($urandom_range(1, 3), $urandom_range(0, 3), bl[$urandom_range(0, 5)],
                1'($urandom_range(0, 1)), 6'($urandom));
    busy_len = 0;
    start(2, 0, 8'h01);
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk_100M);
      if (scan_done) ok = 1'b1;
    end
    chk("held scan completes", ok, 1);
    cnt = 0;
    repeat (1000) begin
      @(negedge clk_100M);
      if (scan_busy) cnt++;
    end
    chk("held run no restart", cnt, 0);
    chk("held line_count", line_count, 2);
    start(5, 0, 8'h01);
    wait_line2_step(ok);
    chk("abort reach line2 step", ok, 1);
    run = '0;
    @(negedge clk_100M);
    chk("abort step 2nd cycle", motor_step, 1);
    @(negedge clk_100M);
    chk("abort step dropped", motor_step, 0);
    chk("abort busy", scan_busy, 0);
    chk("abort en", motor_en, 0);
    dn = 0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk_100M);
      if (scan_done) dn++;
      if (scan_busy) cnt++;
    end
    chk("abort no done", dn, 0);
    chk("abort stays idle", cnt, 0);
    chk("abort line_count", line_count, 1);
    start(5, 0, 8'h01);
    @(negedge clk_100M);
    chk("restart busy", scan_busy, 1);
    chk("restart line_count", line_count, 0);
    run = '0;
    repeat (3) @(negedge clk_100M);
    chk("restart abort idle", scan_busy, 0);
    start(5, 0, 8'h01);
    wait_line2_step(ok);
    chk("reset reach line2 step", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst outputs", {motor_step, motor_en, scan_busy, line_trig, line_count}, 0);
    run = '0;
    @(negedge clk_100M);
    rst_n = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk_100M);
      if (scan_busy) cnt++;
    end
    chk("post reset idle", cnt, 0);
    start(1, 0, 8'h01);
    @(negedge clk_100M);
    chk("post reset restart", scan_busy, 1);
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk_100M);
      if (scan_done) ok = 1'b1;
    end
    chk("post reset scan done", ok, 1);
    run = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Downstream consumer of the host command parser's `run`, `lines` and `reso_div` registers.
- Runs a film scan: drives the stepper motor (step/dir/enable) and issues per-line capture triggers to the CCD/AFE readout.
- Paces each line on the readout's busy flag.
- Reports progress and completion back to the parser/host.

Parameters:
STEP_PERIOD, 1000, clk_100M cycles per motor step (total period, high + low); must be > STEP_PULSE_W.
STEP_PULSE_W, 200, cycles motor_step is held high per step (>= 1).
LINE_TRIG_W, 10, cycles line_trig is held high per line (>= 1).
SETTLE_CYCLES, 100000, cycles between motor enable and first line trigger (>= 1).

Ports:
clk_100M  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
run  in  8  run control from parser; bit0 = scan enable, bit1 = direction; bits 7:2 ignored
lines  in  24  number of lines to scan
reso_div  in  8  resolution divider minus 1; motor steps per line = reso_div+1
ccd_busy  in  1  high while CCD line readout in progress; must rise within the line_trig pulse
motor_en  out  1  stepper driver enable
motor_dir  out  1  stepper direction
motor_step  out  1  step pulse
line_trig  out  1  line capture trigger
scan_busy  out  1  high in any state other than IDLE
scan_done  out  1  one-cycle pulse on normal completion
line_count  out  24  lines completed in current/last scan

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, internal run0_q = 0. Reset mid-scan drops motor_step/motor_en the same instant; no scan_done.
- All outputs registered. States: IDLE, SETTLE, TRIG, WAIT_CCD, STEP_HI, STEP_LO, DONE.
- Start condition: rising edge of run[0] (run[0]=1 and run0_q=0) seen in IDLE.
  - If lines != 0: latch lines, reso_div and run[1]; clear line_count; go SETTLE.
  - If lines == 0: no action, stay IDLE.
  - run[0] held high after a scan does not restart; a new 0->1 edge is required.
  - Register inputs change mid-scan: no effect (latched copies used).
- SETTLE: motor_en=1, motor_dir=latched dir, SETTLE_CYCLES cycles, then TRIG.
- TRIG: line_trig=1 for exactly LINE_TRIG_W cycles, then WAIT_CCD.
- WAIT_CCD: exit on the first cycle ccd_busy==0, to STEP_HI. Step counter cleared.
- STEP_HI: motor_step=1 for STEP_PULSE_W cycles, then STEP_LO.
- STEP_LO: motor_step=0 for STEP_PERIOD-STEP_PULSE_W cycles. On exit, step counter increments.
  - If steps < reso_div+1: back to STEP_HI.
  - Else line_count increments (visible the next cycle); then DONE if line_count+1 == latched lines, otherwise TRIG.
- reso_div=255 gives 256 steps per line; use a 9-bit step counter, no wrap.
- DONE: scan_done=1 for one cycle; motor_en=0 next cycle; go IDLE.
- line_count holds its final value until the next start.
- Abort: run[0]==0 sampled in any non-IDLE state returns to IDLE.
  - SETTLE/TRIG/WAIT_CCD/STEP_LO: next cycle.
  - STEP_HI: the current step pulse completes its full STEP_PULSE_W first (driver minimum pulse).
  - On abort: line_trig and motor_en drop on the IDLE transition; no scan_done; line_count holds the partial value.
  - Abort in the same cycle as DONE: DONE takes priority (scan_done still pulses).
- Unbroken run[0]=1 from start to completion is required for a normal scan.
- Cycle counter width: ceil(log2(max(STEP_PERIOD, SETTLE_CYCLES)))+1 bits, reloaded on every state entry.

Test Plan:
All tests use STEP_PERIOD=8, STEP_PULSE_W=2, LINE_TRIG_W=2, SETTLE_CYCLES=4.
1. lines=3, reso_div=0, run=0x01 edge, ccd_busy=0 -> motor_en high.
   - First line_trig 4 cycles after SETTLE entry; then 3 trig/step pairs, each line 2+1+8 = 11 cycles.
   - Exactly 3 step pulses of width 2; scan_done single pulse; line_count=3; motor_en low after.
2. lines=2, reso_div=3, run=0x03 -> motor_dir=1 throughout; 8 step pulses total, spaced 8 cycles; 2 line_trig pulses; line_count=2.
3. lines=2, reso_div=0, ccd_busy high 20 cycles from each trig rise -> first motor_step rises the cycle after ccd_busy falls; no step while ccd_busy=1.
4. lines=5, drop run[0] during the 1st cycle of a STEP_HI on line 2.
   - Step pulse still 2 cycles wide; then IDLE; motor_en=0.
   - No scan_done; line_count=1; a new run[0] edge restarts with line_count cleared.
5. lines=0 with run[0] edge -> scan_busy stays 0, no outputs toggle.
   - After a completed scan with run[0] held high -> no restart for 1000 cycles.
6. rst_n low mid STEP_HI of line 2 -> motor_step, motor_en, scan_busy, line_count all 0 immediately (asynchronous, before the next clock edge).
   - After release, the sequencer stays IDLE until a fresh run[0] edge.
